// File: rtl/mod_reduce_final_pkg.sv
// Shared sizing constants and FSM state encoding for the final modular reduction stage.
package mod_reduce_final_pkg;

    localparam int MUL_SIZE = 56;
    localparam int RADIX    = 54;
    localparam int MAX_ITER = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_cond_sub.sv
// Combinational t >= m compare and t - m, sharing one subtractor (the borrow gives the compare).
module mod_cond_sub #(
    parameter int width = 56
) (
    input  logic [width-1:0] t,
    input  logic [width-1:0] m,
    output logic             ge,
    output logic [width-1:0] diff
);

    logic borrow;

    assign {borrow, diff} = {1'b0, t} - {1'b0, m};
    assign ge             = ~borrow;

endmodule

// File: rtl/mod_reduce_final.sv
// Reduces t = {in_hi, in_mid} modulo M by bounded repeated conditional subtraction.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready high
// SUB    | one conditional subtraction per cycle until t < M or the iteration cap
// DONE   | result presented on out_*, held until out_ready
module mod_reduce_final #(
    parameter int mul_size = mod_reduce_final_pkg::MUL_SIZE,
    parameter int radix    = mod_reduce_final_pkg::RADIX,
    parameter int MAX_ITER = mod_reduce_final_pkg::MAX_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_hi,
    input  logic [radix-1:0] in_mid,
    input  logic [radix-1:0] mod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [radix-1:0] out_res,
    output logic [2:0]       out_iter,
    output logic             out_err
);

    import mod_reduce_final_pkg::*;

    localparam logic [2:0] ITER_CAP = 3'(MAX_ITER);

    state_t              state_q;
    state_t              state_d;
    logic [mul_size-1:0] t_q;
    logic [radix-1:0]    m_q;
    logic [2:0]          cnt_q;
    logic [mul_size-1:0] m_ext;
    logic [mul_size-1:0] diff;
    logic                ge;
    logic                at_cap;

    assign m_ext  = {{(mul_size-radix){1'b0}}, m_q};
    assign at_cap = (cnt_q == ITER_CAP);

    mod_cond_sub #(.width(mul_size)) u_cond_sub (
        .t    (t_q),
        .m    (m_ext),
        .ge   (ge),
        .diff (diff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_SUB;
            S_SUB:   if (!ge || at_cap) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers are only written on SUB exit, so they hold through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            out_res  <= '0;
            out_iter <= '0;
            out_err  <= 1'b0;
        end else if (state_q == S_IDLE && in_valid) begin
            t_q   <= {in_hi, in_mid};
            m_q   <= mod;
            cnt_q <= '0;
        end else if (state_q == S_SUB) begin
            if (ge && !at_cap) begin
                t_q   <= diff;
                cnt_q <= cnt_q + 3'd1;
            end else begin
                out_res  <= t_q[radix-1:0];
                out_iter <= cnt_q;
                out_err  <= ge;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_mod_reduce_final.sv
// Directed-vector bench for mod_reduce_final with hand-computed expected results.
module tb_mod_reduce_final;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_hi;
    logic [53:0] in_mid;
    logic [53:0] mod;
    logic        out_valid;
    logic        out_ready;
    logic [53:0] out_res;
    logic [2:0]  out_iter;
    logic        out_err;

    int n_total;
    int n_pass;

    localparam logic [53:0] M53   = 54'h20_0000_0000_0001;   // 2^53 + 1
    localparam logic [53:0] ALL54 = 54'h3F_FFFF_FFFF_FFFF;   // 2^54 - 1

    mod_reduce_final dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hi     (in_hi),
        .in_mid    (in_mid),
        .mod       (mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_iter  (out_iter),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts rising edges after the accept edge up to the edge at which
    // a consumer first samples out_valid high.
    task automatic do_op(input string tag, input logic [1:0] hi, input logic [53:0] mid,
                         input logic [53:0] m, input logic [53:0] exp_res,
                         input logic [2:0] exp_iter, input logic exp_err,
                         input int exp_lat, input int hold);
        int          edges;
        logic        stable;
        logic [53:0] res_snap;
        logic [2:0]  iter_snap;
        logic        err_snap;
        @(negedge clk);
        in_hi    = hi;
        in_mid   = mid;
        mod      = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_hi    = 2'($urandom);
        in_mid   = {22'($urandom), 32'($urandom)};
        mod      = {22'($urandom), 32'($urandom)};
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_lat"}, 64'(edges + 1), 64'(exp_lat));
        chk({tag, "_res"}, 64'(out_res), 64'(exp_res));
        chk({tag, "_iter"}, 64'(out_iter), 64'(exp_iter));
        chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        if (hold > 0) begin
            res_snap  = out_res;
            iter_snap = out_iter;
            err_snap  = out_err;
            stable    = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (out_res !== res_snap || out_iter !== iter_snap || out_err !== err_snap ||
                    out_valid !== 1'b1 || in_ready !== 1'b0)
                    stable = 1'b0;
            end
            chk({tag, "_hold"}, 64'(stable), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic seen;
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_hi     = '0;
        in_mid    = '0;
        mod       = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_res", 64'(out_res), 64'd0);
        chk("rst_iter", 64'(out_iter), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // t < M: no subtraction
        do_op("small", 2'd0, 54'd5, M53, 54'd5, 3'd0, 1'b0, 2, 0);
        // t = 3M exactly
        do_op("three_m", 2'd1, 54'h20_0000_0000_0003, M53, 54'd0, 3'd3, 1'b0, 5, 0);
        // t = 2^56-1 with M = 2^53+1: seven subtractions land below M, held for 10 cycles
        do_op("max_t", 2'd3, ALL54, M53, 54'h1F_FFFF_FFFF_FFF8, 3'd7, 1'b0, 9, 10);
        // M = 1: iteration cap reached with t still >= M
        do_op("cap_err", 2'd3, ALL54, 54'd1, 54'h3F_FFFF_FFFF_FFF8, 3'd7, 1'b1, 9, 0);
        // M = 0 must terminate with an error
        do_op("mod_zero", 2'd0, 54'd12345, 54'd0, 54'd12345, 3'd7, 1'b1, 9, 0);
        // t just below 2M
        do_op("two_m_less", 2'd1, 54'h00_0000_0000_0000, M53, 54'h1F_FFFF_FFFF_FFFF, 3'd1, 1'b0, 3, 0);

        // reset mid-operation, with the previous result still registered
        do_op("pre_rst", 2'd3, ALL54, M53, 54'h1F_FFFF_FFFF_FFF8, 3'd7, 1'b0, 9, 0);
        @(negedge clk);
        in_hi    = 2'd1;
        in_mid   = 54'h20_0000_0000_0003;
        mod      = M53;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_res", 64'(out_res), 64'd0);
        chk("midrst_iter", 64'(out_iter), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_stale", 64'(seen), 64'd0);

        do_op("after_rst", 2'd0, 54'd5, M53, 54'd5, 3'd0, 1'b0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
